// File: rtl/add_rs_scheduler.sv
// Issue controller for the add/sub unit: picks a ready reservation station, drives the exec
// handshake and broadcasts the result on the CDB. Define ADD_SCHED_RR_EN for round-robin grant.
module add_rs_scheduler #(
    parameter int unsigned NUM_RS  = 3,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned RES_W   = 16,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic                     clk1,
    input  logic                     rst,
    input  logic [NUM_RS-1:0]        rs_busy,
    input  logic [NUM_RS-1:0]        rs_q1_ok,
    input  logic [NUM_RS-1:0]        rs_q2_ok,
    input  logic [NUM_RS*DATA_W-1:0] rs_v1,
    input  logic [NUM_RS*DATA_W-1:0] rs_v2,
    input  logic [NUM_RS*4-1:0]      rs_func,
    input  logic [NUM_RS*3-1:0]      rs_rob,
    input  logic [NUM_RS*4-1:0]      rs_rd,
    input  logic                     flush,
    input  logic                     ex_done,
    input  logic [RES_W-1:0]         ex_result,
    output logic                     ex_b,
    output logic [2:0]               ex_rs_index,
    output logic [DATA_W-1:0]        ex_rs1_data,
    output logic [DATA_W-1:0]        ex_rs2_data,
    output logic [3:0]               ex_func,
    output logic [2:0]               ex_rob_ind,
    output logic [3:0]               ex_rd,
    output logic [NUM_RS-1:0]        rs_clear,
    output logic                     cdb_valid,
    output logic [2:0]               cdb_rob,
    output logic [3:0]               cdb_rd,
    output logic [RES_W-1:0]         cdb_data,
    output logic                     timeout_err
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StBcast} state_e;

    state_e              state_q, state_d;
    logic [2:0]          grant_q, grant_d;
    logic [DATA_W-1:0]   rs1_q, rs1_d, rs2_q, rs2_d;
    logic [3:0]          func_q, func_d, rd_q, rd_d, cdb_rd_q, cdb_rd_d;
    logic [2:0]          rob_q, rob_d, cdb_rob_q, cdb_rob_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [NUM_RS-1:0]   clear_q, clear_d;
    logic                cdb_valid_q, cdb_valid_d;
    logic [RES_W-1:0]    cdb_data_q, cdb_data_d;
    logic                timeout_q, timeout_d;
`ifdef ADD_SCHED_RR_EN
    logic [2:0]          rr_ptr_q, rr_ptr_d;
`endif

    logic [NUM_RS-1:0]   elig;
    logic                grant_found;
    logic [2:0]          grant_idx;
    logic [NUM_RS-1:0]   clear_vec;

    // An entry whose free pulse is in flight is not yet released by the RS array; skip it.
    assign elig      = rs_busy & rs_q1_ok & rs_q2_ok & ~clear_q;
    assign clear_vec = NUM_RS'(1) << grant_q;

    always_comb begin
        int j;
        j           = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        // Descending scan so the first candidate in search order wins.
        for (int k = int'(NUM_RS) - 1; k >= 0; k--) begin
`ifdef ADD_SCHED_RR_EN
            j = int'(rr_ptr_q) + k;
            if (j >= int'(NUM_RS)) j = j - int'(NUM_RS);
`else
            j = k;
`endif
            if (elig[j]) begin
                grant_found = 1'b1;
                grant_idx   = 3'(j);
            end
        end
    end

    always_comb begin
        int gi;
        gi          = int'(grant_idx);
        state_d     = state_q;
        grant_d     = grant_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        func_d      = func_q;
        rob_d       = rob_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        clear_d     = '0;
        cdb_valid_d = 1'b0;
        cdb_data_d  = cdb_data_q;
        cdb_rob_d   = cdb_rob_q;
        cdb_rd_d    = cdb_rd_q;
        timeout_d   = timeout_q;
`ifdef ADD_SCHED_RR_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    grant_d = grant_idx;
                    rs1_d   = rs_v1[gi*int'(DATA_W) +: DATA_W];
                    rs2_d   = rs_v2[gi*int'(DATA_W) +: DATA_W];
                    func_d  = rs_func[gi*4 +: 4];
                    rob_d   = rs_rob[gi*3 +: 3];
                    rd_d    = rs_rd[gi*4 +: 4];
                    state_d = StIssue;
`ifdef ADD_SCHED_RR_EN
                    rr_ptr_d = (gi + 1 >= int'(NUM_RS)) ? 3'd0 : 3'(gi + 1);
`endif
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 6'd1;
                if (flush) begin
                    clear_d = clear_vec;
                    state_d = StIdle;
                end else if (ex_done) begin
                    clear_d     = clear_vec;
                    cdb_valid_d = 1'b1;
                    cdb_data_d  = ex_result;
                    cdb_rob_d   = rob_q;
                    cdb_rd_d    = rd_q;
                    state_d     = StBcast;
                end else if (cnt_q == 6'(TIMEOUT)) begin
                    timeout_d = 1'b1;
                    clear_d   = clear_vec;
                    state_d   = StIdle;
                end
            end
            StBcast: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            func_q      <= '0;
            rob_q       <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            clear_q     <= '0;
            cdb_valid_q <= 1'b0;
            cdb_data_q  <= '0;
            cdb_rob_q   <= '0;
            cdb_rd_q    <= '0;
            timeout_q   <= 1'b0;
`ifdef ADD_SCHED_RR_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            func_q      <= func_d;
            rob_q       <= rob_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            clear_q     <= clear_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_data_q  <= cdb_data_d;
            cdb_rob_q   <= cdb_rob_d;
            cdb_rd_q    <= cdb_rd_d;
            timeout_q   <= timeout_d;
`ifdef ADD_SCHED_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign ex_b        = (state_q == StIssue);
    assign ex_rs_index = grant_q;
    assign ex_rs1_data = rs1_q;
    assign ex_rs2_data = rs2_q;
    assign ex_func     = func_q;
    assign ex_rob_ind  = rob_q;
    assign ex_rd       = rd_q;
    assign rs_clear    = clear_q;
    assign cdb_valid   = cdb_valid_q;
    assign cdb_rob     = cdb_rob_q;
    assign cdb_rd      = cdb_rd_q;
    assign cdb_data    = cdb_data_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_add_rs_scheduler.sv
// Self-checking bench for add_rs_scheduler: directed scenarios plus a cycle-level reference
// model compared against every output each cycle.
module tb_add_rs_scheduler;

    localparam int NRS = 3;
    localparam int TO  = 63;

    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  rs_busy = '0, rs_q1_ok = '0, rs_q2_ok = '0;
    logic [23:0] rs_v1 = '0, rs_v2 = '0;
    logic [11:0] rs_func = '0, rs_rd = '0;
    logic [8:0]  rs_rob = '0;
    logic        flush = 1'b0, ex_done = 1'b0;
    logic [15:0] ex_result = '0;
    logic        ex_b, cdb_valid, timeout_err;
    logic [2:0]  ex_rs_index, ex_rob_ind, cdb_rob, rs_clear;
    logic [7:0]  ex_rs1_data, ex_rs2_data;
    logic [3:0]  ex_func, ex_rd, cdb_rd;
    logic [15:0] cdb_data;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    add_rs_scheduler dut (
        .clk1(clk1), .rst(rst), .rs_busy(rs_busy), .rs_q1_ok(rs_q1_ok), .rs_q2_ok(rs_q2_ok),
        .rs_v1(rs_v1), .rs_v2(rs_v2), .rs_func(rs_func), .rs_rob(rs_rob), .rs_rd(rs_rd),
        .flush(flush), .ex_done(ex_done), .ex_result(ex_result), .ex_b(ex_b),
        .ex_rs_index(ex_rs_index), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_func(ex_func), .ex_rob_ind(ex_rob_ind), .ex_rd(ex_rd), .rs_clear(rs_clear),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_rd(cdb_rd), .cdb_data(cdb_data),
        .timeout_err(timeout_err)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 2 time units after each rising edge.
    task automatic step();
        @(posedge clk1);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_ex_b(input string name);
        int n;
        n = 0;
        while (ex_b !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check(name, 64'(ex_b), 64'd1);
    endtask

    // ---------------- reference model ----------------
    bit          m_busy, m_strobe, m_retiring;
    int          m_waited, m_rr, m_g;
    logic        exp_ex_b, exp_cdb_valid, exp_to;
    logic [2:0]  exp_idx, exp_clear;
    logic [26:0] exp_ex;
    logic [22:0] exp_cdb;

    function automatic int pick(input logic [2:0] avail, input int start);
        for (int k = 0; k < NRS; k++) begin
            int j;
            j = (start + k) % NRS;
            if (avail[j]) return j;
        end
        return -1;
    endfunction

    initial begin
        m_busy = 0; m_strobe = 0; m_retiring = 0; m_waited = 0; m_rr = 0; m_g = 0;
        exp_ex_b = 0; exp_cdb_valid = 0; exp_to = 0; exp_idx = 0; exp_clear = 0;
        exp_ex = 0; exp_cdb = 0;
    end

    always @(posedge clk1) begin : model
        logic [2:0] avail;
        logic [2:0] nclr;
        logic       nval;
        int         g;
        if (rst) begin
            m_busy = 0; m_strobe = 0; m_retiring = 0; m_waited = 0; m_rr = 0; m_g = 0;
            exp_idx = 0; exp_ex = 0; exp_clear = 0; exp_cdb = 0; exp_to = 0;
            exp_cdb_valid = 0;
        end else begin
            nclr = '0;
            nval = 1'b0;
            if (m_retiring) begin
                m_retiring = 0;
                m_busy = 0;
            end else if (!m_busy) begin
                avail = rs_busy & rs_q1_ok & rs_q2_ok & ~exp_clear;
`ifdef ADD_SCHED_RR_EN
                g = pick(avail, m_rr);
`else
                g = pick(avail, 0);
`endif
                if (g >= 0) begin
                    m_busy = 1; m_strobe = 1; m_g = g;
                    m_rr = (g + 1) % NRS;
                    exp_idx = 3'(g);
                    exp_ex = {rs_v1[g*8 +: 8], rs_v2[g*8 +: 8], rs_func[g*4 +: 4],
                              rs_rob[g*3 +: 3], rs_rd[g*4 +: 4]};
                end
            end else if (m_strobe) begin
                m_strobe = 0;
                m_waited = 0;
            end else if (flush) begin
                nclr[m_g] = 1'b1;
                m_busy = 0;
            end else if (ex_done) begin
                nclr[m_g] = 1'b1;
                nval = 1'b1;
                exp_cdb = {exp_ex[6:4], exp_ex[3:0], ex_result};
                m_retiring = 1;
            end else if (m_waited == TO) begin
                exp_to = 1'b1;
                nclr[m_g] = 1'b1;
                m_busy = 0;
            end else begin
                m_waited++;
            end
            exp_clear = nclr;
            exp_cdb_valid = nval;
        end
        exp_ex_b = m_strobe;
    end

    always @(negedge clk1) begin
        if (chk_en) begin
            check("m_ex_b", 64'(ex_b), 64'(exp_ex_b));
            check("m_index", 64'(ex_rs_index), 64'(exp_idx));
            check("m_ex_fields", 64'({ex_rs1_data, ex_rs2_data, ex_func, ex_rob_ind, ex_rd}),
                  64'(exp_ex));
            check("m_rs_clear", 64'(rs_clear), 64'(exp_clear));
            check("m_cdb", 64'({cdb_valid, cdb_rob, cdb_rd, cdb_data}),
                  64'({exp_cdb_valid, exp_cdb}));
            check("m_timeout", 64'(timeout_err), 64'(exp_to));
        end
    end

    // ---------------- directed scenarios ----------------
    initial begin
        rs_v1   = {8'h33, 8'h22, 8'd5};
        rs_v2   = {8'h44, 8'h11, 8'd3};
        rs_func = {4'h1, 4'h1, 4'h0};
        rs_rob  = {3'd6, 3'd5, 3'd2};
        rs_rd   = {4'd9, 4'd7, 4'd4};
        rs_q1_ok = 3'b111;
        rs_q2_ok = 3'b111;
        step();
        chk_en = 1'b1;
        do_reset();

        // 1: single add
        check("rst_ex_b", 64'(ex_b), 64'd0);
        check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        check("rst_timeout", 64'(timeout_err), 64'd0);
        rs_busy = 3'b001;
        step();
        check("t1_ex_b_latency", 64'(ex_b), 64'd1);
        check("t1_index", 64'(ex_rs_index), 64'd0);
        check("t1_ops", 64'({ex_rs1_data, ex_rs2_data, ex_func}), 64'({8'd5, 8'd3, 4'd0}));
        check("t1_rob_rd", 64'({ex_rob_ind, ex_rd}), 64'({3'd2, 4'd4}));
        rs_busy = 3'b000;
        step();
        check("t1_ex_b_once", 64'(ex_b), 64'd0);
        step();
        ex_done = 1'b1; ex_result = 16'd8;
        step();
        ex_done = 1'b0;
        check("t1_cdb", 64'({cdb_valid, cdb_rob, cdb_rd, cdb_data}),
              64'({1'b1, 3'd2, 4'd4, 16'd8}));
        check("t1_rs_clear", 64'(rs_clear), 64'd1);
        step();
        check("t1_cdb_pulse", 64'({cdb_valid, rs_clear}), 64'd0);

        // 2: all three ready for three ops
        do_reset();
        rs_busy = 3'b111;
        for (int i = 0; i < 3; i++) begin
            wait_ex_b("t2_issue");
`ifdef ADD_SCHED_RR_EN
            check("t2_grant", 64'(ex_rs_index), 64'(i));
`else
            check("t2_grant", 64'(ex_rs_index), 64'd0);
`endif
            step();
            ex_done = 1'b1; ex_result = 16'(100 + i);
            step();
            ex_done = 1'b0;
            check("t2_cdb_valid", 64'(cdb_valid), 64'd1);
        end
        rs_busy = 3'b000;

        // 3: flush beats ex_done
        do_reset();
        rs_busy = 3'b010;
        wait_ex_b("t3_issue");
        check("t3_index", 64'(ex_rs_index), 64'd1);
        rs_busy = 3'b000;
        step();
        flush = 1'b1; ex_done = 1'b1; ex_result = 16'h5555;
        step();
        flush = 1'b0; ex_done = 1'b0;
        check("t3_no_cdb", 64'(cdb_valid), 64'd0);
        check("t3_rs_clear", 64'(rs_clear), 64'b010);
        rs_busy = 3'b100;
        step();
        check("t3_back_idle", 64'({ex_b, ex_rs_index}), 64'({1'b1, 3'd2}));

        // 4: timeout on entry 2
        rs_busy = 3'b000;
        for (int i = 0; i < 64; i++) step();
        check("t4_not_yet", 64'(timeout_err), 64'd0);
        step();
        check("t4_timeout", 64'(timeout_err), 64'd1);
        check("t4_rs_clear", 64'(rs_clear), 64'b100);
        step();
        check("t4_clear_once", 64'(rs_clear), 64'd0);
        rs_busy = 3'b001;
        step();
        check("t4_next_issue", 64'({ex_b, ex_rs_index}), 64'({1'b1, 3'd0}));
        check("t4_sticky", 64'(timeout_err), 64'd1);

        // 5: reset during WAIT
        rs_busy = 3'b000;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_outputs_zero", 64'({ex_b, ex_rs_index, ex_rs1_data, ex_rs2_data, ex_func,
              ex_rob_ind, ex_rd, rs_clear, cdb_valid, cdb_rob, cdb_rd, cdb_data, timeout_err}),
              64'd0);
        ex_done = 1'b1; ex_result = 16'h7777;
        step();
        ex_done = 1'b0;
        check("t5_done_ignored", 64'({cdb_valid, rs_clear}), 64'd0);
        step();
        check("t5_still_quiet", 64'({cdb_valid, ex_b}), 64'd0);

        // 6: operands frozen at grant; odd func still issues
        rs_func[7:4] = 4'hA;
        rs_busy = 3'b010;
        wait_ex_b("t6_issue");
        check("t6_func", 64'({ex_rs_index, ex_func}), 64'({3'd1, 4'hA}));
        rs_busy = 3'b000;
        rs_v1[15:8] = 8'hEE;
        step();
        step();
        check("t6_rs1_held", 64'(ex_rs1_data), 64'h22);
        ex_done = 1'b1; ex_result = 16'hBEEF;
        step();
        ex_done = 1'b0;
        check("t6_cdb", 64'({cdb_valid, cdb_rob, cdb_rd, cdb_data, rs_clear}),
              64'({1'b1, 3'd5, 4'd7, 16'hBEEF, 3'b010}));
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
